// File: rtl/ks10_dbm_pkg.sv
// Shared DBM definitions: DBM_SEL source encodings, SELBYTE codes and the
// byte-sequencer state encoding.
package ks10_dbm_pkg;

  typedef enum logic [2:0] {
    DBM_SCADPFAPR = 3'd0,
    DBM_BYTES     = 3'd1,
    DBM_EXPTIME   = 3'd2,
    DBM_DP        = 3'd3,
    DBM_DPSWAP    = 3'd4,
    DBM_VMA       = 3'd5,
    DBM_MEM       = 3'd6,
    DBM_NUM       = 3'd7
  } dbm_sel_e;

  localparam logic [2:0] SELBYTE_NONE  = 3'd0;
  localparam logic [2:0] SELBYTE_FIRST = 3'd1;
  localparam logic [2:0] SELBYTE_LAST  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_FILL = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } seq_state_e;

  // Out-of-range start positions fall back to the first byte of the word.
  function automatic logic [2:0] clamp_pos(input logic [2:0] p);
    if ((p < SELBYTE_FIRST) || (p > SELBYTE_LAST)) return SELBYTE_FIRST;
    return p;
  endfunction

endpackage

// File: rtl/dbm_byte_pos.sv
// Byte position counter for the DBM byte sequencer: clamped load, increment
// with 5->1 wrap, rewind to byte 1, clear to 0, and a terminal (byte 5) flag.
module dbm_byte_pos
  import ks10_dbm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic [2:0] load_pos,
  input  logic       rewind,
  input  logic       inc,
  output logic [2:0] pos,
  output logic       terminal
);

  logic [2:0] pos_d, pos_q;

  always_comb begin
    pos_d = pos_q;
    if (clear)       pos_d = SELBYTE_NONE;
    else if (load)   pos_d = clamp_pos(load_pos);
    else if (rewind) pos_d = SELBYTE_FIRST;
    else if (inc)    pos_d = (pos_q == SELBYTE_LAST) ? SELBYTE_FIRST : pos_q + 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pos_q <= SELBYTE_NONE;
    else     pos_q <= pos_d;
  end

  assign pos      = pos_q;
  assign terminal = (pos_q == SELBYTE_LAST);

endmodule

// File: rtl/dbm_byte_seq.sv
// DBM byte-insert sequencer: read word, insert 7-bit bytes at positions 1..5, write back.
// Define DBM_BYTE_SEQ_PAD_EN to pad the rest of the word with PADCHR after lastBYTE.
module dbm_byte_seq
  import ks10_dbm_pkg::*;
#(
  parameter int unsigned CNTW   = 12,
  parameter logic [6:0]  PADCHR = 7'o000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      startPOS,
  input  logic [CNTW-1:0] wordCNT,
  input  logic            abort,
  input  logic [6:0]      byteIN,
  input  logic            byteVALID,
  output logic            byteREADY,
  input  logic            lastBYTE,
  input  logic            memACK,
  output logic            memREQ,
  output logic            memWR,
  output logic [2:0]      dbmSEL,
  output logic [2:0]      selBYTE,
  output logic [6:0]      byteOUT,
  output logic            busy,
  output logic            done
);

  seq_state_e      state_d, state_q;
  logic [CNTW-1:0] cnt_d, cnt_q;
  logic            last_d, last_q;
  logic            pad_d, pad_q;
  logic            byteready_d, byteready_q;
  logic            memreq_d, memreq_q;
  logic            memwr_d, memwr_q;
  dbm_sel_e        dbmsel_d, dbmsel_q;
  logic [2:0]      selbyte_d, selbyte_q;
  logic [6:0]      byteout_d, byteout_q;
  logic            busy_d, busy_q;
  logic            done_d, done_q;

  logic [2:0] pos;
  logic       pos_term;
  logic       pos_clear, pos_load, pos_rewind, pos_inc;
  logic       hs;

  dbm_byte_pos u_pos (
    .clk      (clk),
    .rst      (rst),
    .clear    (pos_clear),
    .load     (pos_load),
    .load_pos (startPOS),
    .rewind   (pos_rewind),
    .inc      (pos_inc),
    .pos      (pos),
    .terminal (pos_term)
  );

  assign hs = (state_q == ST_FILL) && byteready_q && byteVALID;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    pad_d      = pad_q;
    selbyte_d  = SELBYTE_NONE;
    byteout_d  = byteout_q;
    pos_clear  = 1'b0;
    pos_load   = 1'b0;
    pos_rewind = 1'b0;
    pos_inc    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (wordCNT == '0) begin
            state_d = ST_DONE;
          end else begin
            pos_load = 1'b1;
            cnt_d    = wordCNT;
            last_d   = 1'b0;
            state_d  = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (memACK) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (hs) begin
          selbyte_d = pos;
          byteout_d = byteIN;
          pos_inc   = 1'b1;
          if (lastBYTE) last_d = 1'b1;
          if (pos_term) begin
            state_d = ST_WR;
          end else if (lastBYTE) begin
`ifdef DBM_BYTE_SEQ_PAD_EN
            pad_d = 1'b1;
`else
            state_d = ST_WR;
`endif
          end
        end else if (pad_q) begin
          // Padding runs one position per cycle with the requester held off.
          selbyte_d = pos;
          byteout_d = PADCHR;
          pos_inc   = 1'b1;
          if (pos_term) begin
            pad_d   = 1'b0;
            state_d = ST_WR;
          end
        end
      end
      ST_WR: begin
        if (memACK) begin
          cnt_d      = (cnt_q == '0) ? '0 : cnt_q - CNTW'(1);
          pos_rewind = 1'b1;
          state_d    = ((cnt_d == '0) || last_q) ? ST_DONE : ST_RD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort) state_d = ST_IDLE;

    // Entering IDLE (normally, by abort, or staying) forces every output and counter to 0.
    if (state_d == ST_IDLE) begin
      cnt_d     = '0;
      last_d    = 1'b0;
      pad_d     = 1'b0;
      selbyte_d = SELBYTE_NONE;
      byteout_d = '0;
      pos_clear = 1'b1;
    end
  end

  always_comb begin
    byteready_d = (state_d == ST_FILL) && !pad_d;
    memreq_d    = (state_d == ST_RD) || (state_d == ST_WR);
    memwr_d     = (state_d == ST_WR);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    case (state_d)
      ST_RD:          dbmsel_d = DBM_MEM;
      ST_FILL, ST_WR: dbmsel_d = DBM_DP;
      default:        dbmsel_d = DBM_SCADPFAPR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      pad_q       <= 1'b0;
      byteready_q <= 1'b0;
      memreq_q    <= 1'b0;
      memwr_q     <= 1'b0;
      dbmsel_q    <= DBM_SCADPFAPR;
      selbyte_q   <= SELBYTE_NONE;
      byteout_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      pad_q       <= pad_d;
      byteready_q <= byteready_d;
      memreq_q    <= memreq_d;
      memwr_q     <= memwr_d;
      dbmsel_q    <= dbmsel_d;
      selbyte_q   <= selbyte_d;
      byteout_q   <= byteout_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Abort withdraws the memory request in the same cycle it is raised.
  assign memREQ    = memreq_q & ~abort;
  assign memWR     = memwr_q;
  assign byteREADY = byteready_q;
  assign dbmSEL    = dbmsel_q;
  assign selBYTE   = selbyte_q;
  assign byteOUT   = byteout_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
